// File: rtl/cache_line_mover_if.sv
`default_nettype none
// ============================================================================
// Module   : cache_line_mover_if
// Brief    : Controller-side request/response and main-memory word port
//            bundle for the cache line mover.
// Revision : 1.0 - initial release
// ============================================================================
interface cache_line_mover_if #(
    parameter int TAG_W = 24,
    parameter int SET_W = 3,
    parameter int WORDS = 8
);
    logic                   req_valid;
    logic                   req_wb;
    logic [TAG_W-1:0]       req_tag;
    logic [SET_W-1:0]       req_set;
    logic [TAG_W-1:0]       victim_tag;
    logic [WORDS*32-1:0]    victim_line;
    logic                   busy;
    logic                   done;
    logic [WORDS*32-1:0]    fill_line;
    logic [31:0]            mem_addr;
    logic                   mem_rden;
    logic                   mem_wen;
    logic [31:0]            mem_wdata;
    logic [31:0]            mem_rdata;
    logic                   mem_ack;

    // The mover itself attaches through slave; the controller/memory side through master.
    modport slave (
        input  req_valid, req_wb, req_tag, req_set, victim_tag, victim_line,
        input  mem_rdata, mem_ack,
        output busy, done, fill_line,
        output mem_addr, mem_rden, mem_wen, mem_wdata
    );

    modport master (
        output req_valid, req_wb, req_tag, req_set, victim_tag, victim_line,
        output mem_rdata, mem_ack,
        input  busy, done, fill_line,
        input  mem_addr, mem_rden, mem_wen, mem_wdata
    );
endinterface
`default_nettype wire

// File: rtl/cache_line_mover.sv
`default_nettype none
// ============================================================================
// Module   : cache_line_mover
// Brief    : Burst engine that writes back a dirty victim line (optional) and
//            then fetches a new line one word at a time for the cache.
// Revision : 1.0 - initial release
// ============================================================================
module cache_line_mover #(
    parameter int TAG_W = 24,
    parameter int SET_W = 3,
    parameter int WORDS = 8
) (
    input  wire logic          CLK,
    input  wire logic          reset_n,
    cache_line_mover_if.slave  bus
);
    localparam int CNT_W  = $clog2(WORDS);
    localparam int LINE_W = WORDS * 32;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WB   = 2'd1,
        S_FILL = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [CNT_W-1:0]    r_cnt;
    logic [TAG_W-1:0]    r_tag;
    logic [TAG_W-1:0]    r_vtag;
    logic [SET_W-1:0]    r_set;
    logic [LINE_W-1:0]   r_victim;
    logic [LINE_W-1:0]   r_fill;
    logic                w_last;
    logic [CNT_W+4:0]    w_bit_base;

    assign w_last     = (r_cnt == CNT_W'(WORDS - 1));
    assign w_bit_base = {r_cnt, 5'b00000};

    // State register plus the captured request and the line being assembled.
    always_ff @(posedge CLK) begin
        if (!reset_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_tag    <= '0;
            r_vtag   <= '0;
            r_set    <= '0;
            r_victim <= '0;
            r_fill   <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        r_tag    <= bus.req_tag;
                        r_vtag   <= bus.victim_tag;
                        r_set    <= bus.req_set;
                        r_victim <= bus.victim_line;
                        r_cnt    <= '0;
                    end
                end
                S_WB: begin
                    // Wraps 7 -> 0 exactly when handing over to the fill phase.
                    if (bus.mem_ack) begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_FILL: begin
                    if (bus.mem_ack) begin
                        r_fill[w_bit_base +: 32] <= bus.mem_rdata;
                        r_cnt                    <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        w_next        = r_state;
        bus.busy      = 1'b0;
        bus.done      = 1'b0;
        bus.mem_rden  = 1'b0;
        bus.mem_wen   = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        case (r_state)
            S_IDLE: begin
                if (bus.req_valid) begin
                    w_next = bus.req_wb ? S_WB : S_FILL;
                end
            end
            S_WB: begin
                bus.busy      = 1'b1;
                bus.mem_wen   = 1'b1;
                bus.mem_addr  = {r_vtag, r_set, r_cnt, 2'b00};
                bus.mem_wdata = r_victim[w_bit_base +: 32];
                if (bus.mem_ack && w_last) begin
                    w_next = S_FILL;
                end
            end
            S_FILL: begin
                bus.busy     = 1'b1;
                bus.mem_rden = 1'b1;
                bus.mem_addr = {r_tag, r_set, r_cnt, 2'b00};
                if (bus.mem_ack && w_last) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                bus.busy = 1'b1;
                bus.done = 1'b1;
                w_next   = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    assign bus.fill_line = r_fill;

endmodule
`default_nettype wire

// File: tb/tb_cache_line_mover.sv
`default_nettype none
// ============================================================================
// Module   : tb_cache_line_mover
// Brief    : Self-checking bench: transaction-level reference model plus
//            directed and randomized line requests with a reactive memory.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cache_line_mover;
    localparam int PH_IDLE = 0;
    localparam int PH_OPS  = 1;
    localparam int PH_DONE = 2;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
    } op_t;

    logic clk;
    logic reset_n;
    int   n_chk;
    int   n_err;

    cache_line_mover_if #(.TAG_W(24), .SET_W(3), .WORDS(8)) bus ();

    cache_line_mover #(.TAG_W(24), .SET_W(3), .WORDS(8)) dut (
        .CLK     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Reference model: an accepted request expands into an ordered list of word
    // operations; the line is the read data in acceptance order.
    int            m_phase;
    bit            m_valid;
    bit            m_rst;
    op_t           m_q[$];
    logic [255:0]  m_line;
    int            m_rdk;
    logic [31:0]   obs_addr[$];
    logic [31:0]   obs_wdata[$];
    bit            obs_wr[$];
    int            n_done;

    task automatic model_check();
        op_t op;
        case (m_phase)
            PH_IDLE: begin
                chk("idle_busy", bus.busy, 0);
                chk("idle_done", bus.done, 0);
                chk("idle_rden", bus.mem_rden, 0);
                chk("idle_wen", bus.mem_wen, 0);
                if (m_rst) begin
                    chk("rst_addr", bus.mem_addr, 0);
                    chk("rst_wdata", bus.mem_wdata, 0);
                end
            end
            PH_OPS: begin
                op = m_q[0];
                chk("ops_busy", bus.busy, 1);
                chk("ops_done", bus.done, 0);
                chk("ops_wen", bus.mem_wen, op.wr);
                chk("ops_rden", bus.mem_rden, !op.wr);
                chk("ops_addr", bus.mem_addr, op.addr);
                if (op.wr) chk("ops_wdata", bus.mem_wdata, op.data);
            end
            default: begin
                chk("done_busy", bus.busy, 1);
                chk("done_done", bus.done, 1);
                chk("done_rden", bus.mem_rden, 0);
                chk("done_wen", bus.mem_wen, 0);
            end
        endcase
        chk("fill_line", bus.fill_line, m_line);
    endtask

    task automatic model_advance();
        op_t op;
        if (!reset_n) begin
            m_phase = PH_IDLE;
            m_q.delete();
            m_line  = '0;
            m_rdk   = 0;
            m_valid = 1'b1;
            m_rst   = 1'b1;
            return;
        end
        m_rst = 1'b0;
        case (m_phase)
            PH_IDLE: begin
                if (bus.req_valid) begin
                    m_q.delete();
                    m_rdk = 0;
                    if (bus.req_wb) begin
                        for (int i = 0; i < 8; i++) begin
                            op.wr   = 1'b1;
                            op.addr = {bus.victim_tag, bus.req_set, 3'(i), 2'b00};
                            op.data = bus.victim_line[32*i +: 32];
                            m_q.push_back(op);
                        end
                    end
                    for (int i = 0; i < 8; i++) begin
                        op.wr   = 1'b0;
                        op.addr = {bus.req_tag, bus.req_set, 3'(i), 2'b00};
                        op.data = '0;
                        m_q.push_back(op);
                    end
                    m_phase = PH_OPS;
                end
            end
            PH_OPS: begin
                if (bus.mem_ack && m_q.size() > 0) begin
                    op = m_q.pop_front();
                    if (!op.wr) begin
                        m_line[32*m_rdk +: 32] = bus.mem_rdata;
                        m_rdk++;
                    end
                    if (m_q.size() == 0) m_phase = PH_DONE;
                end
            end
            default: m_phase = PH_IDLE;
        endcase
    endtask

    initial begin
        m_phase = PH_IDLE;
        m_valid = 1'b0;
        m_rst   = 1'b0;
        m_line  = '0;
        m_rdk   = 0;
        n_done  = 0;
        forever begin
            @(negedge clk);
            if (m_valid) begin
                model_check();
                if (bus.done) n_done++;
                if (bus.mem_ack && (bus.mem_wen || bus.mem_rden)) begin
                    obs_addr.push_back(bus.mem_addr);
                    obs_wdata.push_back(bus.mem_wdata);
                    obs_wr.push_back(bus.mem_wen);
                end
            end
            model_advance();
        end
    end

    // Reactive memory: ack policy and read data chosen by the running test.
    int          ack_mode;
    int          rd_mode;
    logic [31:0] rd_base;
    int          pat;

    initial begin
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
        pat = 0;
        forever begin
            @(posedge clk);
            #1;
            case (ack_mode)
                0:       bus.mem_ack = 1'b1;
                1: begin
                    bus.mem_ack = ((pat % 4) == 0) || ((pat % 4) == 3);
                    pat++;
                end
                default: bus.mem_ack = (($urandom % 4) != 0);
            endcase
            if (rd_mode == 0) bus.mem_rdata = rd_base + {29'd0, bus.mem_addr[4:2]};
            else              bus.mem_rdata = $urandom;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (bus.busy && n < 200) begin
            tick();
            n++;
        end
        if (bus.busy) chk("wait_idle_timeout", 1, 0);
    endtask

    task automatic wait_done(output int lat);
        lat = 1;
        while (!bus.done && lat < 400) begin
            tick();
            lat++;
        end
        if (!bus.done) chk("done_timeout", 0, 1);
    endtask

    task automatic rand_inputs();
        bus.req_wb     = 1'($urandom);
        bus.req_tag    = 24'($urandom);
        bus.req_set    = 3'($urandom);
        bus.victim_tag = 24'($urandom);
        for (int i = 0; i < 8; i++) bus.victim_line[32*i +: 32] = $urandom;
    endtask

    // hold=1 keeps req_valid high with fresh random inputs every busy cycle.
    task automatic run_req(input bit wb, input logic [23:0] tag, input logic [2:0] set,
                           input logic [23:0] vtag, input logic [255:0] vline,
                           input bit hold, output int lat);
        wait_idle();
        obs_addr.delete();
        obs_wdata.delete();
        obs_wr.delete();
        bus.req_valid   = 1'b1;
        bus.req_wb      = wb;
        bus.req_tag     = tag;
        bus.req_set     = set;
        bus.victim_tag  = vtag;
        bus.victim_line = vline;
        tick();
        if (!hold) bus.req_valid = 1'b0;
        lat = 1;
        while (!bus.done && lat < 400) begin
            if (hold) rand_inputs();
            tick();
            lat++;
        end
        if (!bus.done) chk("done_timeout", 0, 1);
        bus.req_valid = 1'b0;
    endtask

    function automatic logic [255:0] ramp_line(input logic [31:0] base);
        logic [255:0] l;
        for (int i = 0; i < 8; i++) l[32*i +: 32] = base + 32'(i);
        return l;
    endfunction

    initial begin
        int           lat;
        int           nd;
        logic [255:0] vline;
        logic [23:0]  t;
        logic [2:0]   s;

        n_chk = 0;
        n_err = 0;
        ack_mode = 0;
        rd_mode  = 0;
        rd_base  = 32'h100;
        reset_n  = 1'b0;
        bus.req_valid   = 1'b0;
        bus.req_wb      = 1'b0;
        bus.req_tag     = '0;
        bus.req_set     = '0;
        bus.victim_tag  = '0;
        bus.victim_line = '0;
        repeat (3) tick();
        chk("reset_busy", bus.busy, 0);
        chk("reset_done", bus.done, 0);
        chk("reset_fill", bus.fill_line, 0);
        chk("reset_addr", bus.mem_addr, 0);
        reset_n = 1'b1;
        tick();

        // Plain fill, ack tied high.
        nd = n_done;
        run_req(1'b0, 24'hABCDE0, 3'd3, 24'h0, 256'h0, 1'b0, lat);
        chk("t1_latency", lat, 9);
        chk("t1_nwords", obs_addr.size(), 8);
        chk("t1_addr0", obs_addr[0], 32'hABCDE060);
        chk("t1_addr1", obs_addr[1], 32'hABCDE064);
        chk("t1_addr7", obs_addr[7], 32'hABCDE07C);
        chk("t1_fill", bus.fill_line, ramp_line(32'h100));
        tick();
        chk("t1_done_once", bus.done, 0);
        chk("t1_ndone", n_done - nd, 1);

        // Writeback then fill.
        vline = ramp_line(32'hA0);
        run_req(1'b1, 24'h000456, 3'd5, 24'h000123, vline, 1'b0, lat);
        chk("t2_latency", lat, 17);
        chk("t2_nwords", obs_addr.size(), 16);
        chk("t2_w0_addr", obs_addr[0], 32'h000123A0);
        chk("t2_w0_wr", obs_wr[0], 1);
        chk("t2_w0_data", obs_wdata[0], 32'hA0);
        chk("t2_w7_addr", obs_addr[7], 32'h000123BC);
        chk("t2_w7_data", obs_wdata[7], 32'hA7);
        chk("t2_r0_addr", obs_addr[8], 32'h000456A0);
        chk("t2_r0_wr", obs_wr[8], 0);
        chk("t2_r7_addr", obs_addr[15], 32'h000456BC);

        // Stalling memory: ack pattern 1,0,0,1.
        ack_mode = 1;
        pat = 0;
        run_req(1'b0, 24'h5A5A5A, 3'd2, 24'h0, 256'h0, 1'b0, lat);
        chk("t3_nwords", obs_addr.size(), 8);
        for (int i = 0; i < 8; i++) chk("t3_order", obs_addr[i], {24'h5A5A5A, 3'd2, 3'(i), 2'b00});
        chk("t3_fill", bus.fill_line, ramp_line(32'h100));
        ack_mode = 0;

        // Request inputs toggling while busy.
        run_req(1'b1, 24'h00BEEF, 3'd6, 24'h00CAFE, vline, 1'b1, lat);
        chk("t4_latency", lat, 17);
        chk("t4_w0_addr", obs_addr[0], 32'h00CAFEC0);
        chk("t4_w3_data", obs_wdata[3], 32'hA3);
        chk("t4_r0_addr", obs_addr[8], 32'h00BEEFC0);
        chk("t4_fill", bus.fill_line, ramp_line(32'h100));
        repeat (2) tick();
        chk("t4_single", bus.busy, 0);

        // Reset in the middle of writeback.
        bus.req_valid   = 1'b1;
        bus.req_wb      = 1'b1;
        bus.req_tag     = 24'h111111;
        bus.req_set     = 3'd1;
        bus.victim_tag  = 24'h222222;
        bus.victim_line = vline;
        tick();
        bus.req_valid = 1'b0;
        lat = 0;
        while (!(bus.mem_wen && bus.mem_addr[4:2] == 3'd4) && lat < 50) begin
            tick();
            lat++;
        end
        chk("t5_reach_w4", bus.mem_wen && bus.mem_addr[4:2] == 3'd4, 1);
        nd = n_done;
        reset_n = 1'b0;
        tick();
        chk("t5_busy", bus.busy, 0);
        chk("t5_wen", bus.mem_wen, 0);
        chk("t5_fill", bus.fill_line, 0);
        chk("t5_done", bus.done, 0);
        reset_n = 1'b1;
        tick();
        chk("t5_no_done", n_done - nd, 0);
        run_req(1'b0, 24'h333333, 3'd7, 24'h0, 256'h0, 1'b0, lat);
        chk("t5_latency", lat, 9);
        chk("t5_addr0", obs_addr[0], 32'h333333E0);
        chk("t5_fill", bus.fill_line, ramp_line(32'h100));

        // Back-to-back with req_valid held high.
        wait_idle();
        bus.req_valid = 1'b1;
        bus.req_wb    = 1'b0;
        bus.req_tag   = 24'h444444;
        bus.req_set   = 3'd0;
        tick();
        wait_done(lat);
        chk("t6_first_fill", bus.fill_line, ramp_line(32'h100));
        bus.req_tag = 24'h555555;
        rd_base     = 32'h900;
        tick();
        chk("t6_gap_idle", bus.busy, 0);
        chk("t6_gap_hold", bus.fill_line, ramp_line(32'h100));
        tick();
        chk("t6_second_cap", bus.busy, 1);
        bus.req_valid = 1'b0;
        wait_done(lat);
        chk("t6_second_lat", lat, 9);
        chk("t6_second_fill", bus.fill_line, ramp_line(32'h900));

        // Randomized traffic with stalls, toggling inputs and occasional resets.
        ack_mode = 2;
        rd_mode  = 1;
        for (int k = 0; k < 30; k++) begin
            repeat ($urandom % 3) tick();
            t = 24'($urandom);
            s = 3'($urandom);
            for (int i = 0; i < 8; i++) vline[32*i +: 32] = $urandom;
            if (($urandom % 6) == 0) begin
                wait_idle();
                bus.req_valid = 1'b1;
                rand_inputs();
                tick();
                bus.req_valid = 1'b0;
                repeat ($urandom % 20) tick();
                reset_n = 1'b0;
                tick();
                reset_n = 1'b1;
            end else begin
                run_req(1'($urandom), t, s, 24'($urandom), vline, 1'($urandom), lat);
            end
        end
        repeat (4) tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/cache_line_mover.md
Name: cache_line_mover

Overview:
- Memory-side burst engine directly downstream of the cache controller.
- On a miss, the controller hands it one line request. The engine optionally writes back the dirty victim line (8 words), then fetches the new line (8 words) from main memory one word at a time.
- The assembled 256-bit line is returned to the controller together with a one-cycle done pulse, so the controller can fill its data array and release the CPU stall.

Parameters:
- TAG_W, 24, tag width; equals address width minus SET_W minus 5 offset bits.
- SET_W, 3, set index width (8 sets).
- WORDS, 8, 32-bit words per line; the line is 256 bits and the word counter is 3 bits.

Ports:
- CLK  in  1  rising-edge clock.
- reset_n  in  1  synchronous, active-low reset.
- req_valid  in  1  controller requests a line operation; sampled only in IDLE.
- req_wb  in  1  victim is dirty; write it back before the fill.
- req_tag  in  TAG_W  tag of the line to fetch.
- req_set  in  SET_W  set index, shared by victim and new line.
- victim_tag  in  TAG_W  tag of the victim line.
- victim_line  in  256  victim data; word i = bits [32i+31:32i].
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when fill_line is valid.
- fill_line  out  256  fetched line; held until the next accepted request.
- mem_addr  out  32  word address to main memory.
- mem_rden  out  1  read request.
- mem_wen  out  1  write request.
- mem_wdata  out  32  write data.
- mem_rdata  in  32  read data; valid when mem_ack=1 and mem_rden=1.
- mem_ack  in  1  memory accepts or completes the current word this cycle.

Behaviour:
- States: IDLE, WB, FILL, DONE. State is encoded in 2 bits.
- Reset (reset_n=0 at a clock edge), including mid-burst:
  - state goes to IDLE and the word counter clears to 0;
  - busy, done, mem_rden and mem_wen go to 0;
  - mem_addr, mem_wdata and fill_line clear to 0;
  - any partial transfer is abandoned.
- IDLE:
  - if req_valid=1, latch req_wb, req_tag, req_set, victim_tag and victim_line into internal registers, and clear the word counter to 0;
  - next state is WB if req_wb=1, otherwise FILL.
  - Input changes after the capture edge have no effect.
- WB:
  - mem_wen=1, mem_rden=0;
  - mem_addr = {victim_tag, set, cnt, 2'b00};
  - mem_wdata = latched victim word[cnt].
  - Each cycle with mem_ack=1 increments cnt. If cnt=WORDS-1, go to FILL with cnt=0 instead.
  - With mem_ack=0, all memory outputs hold (stall), with no timeout.
- FILL:
  - mem_rden=1, mem_wen=0;
  - mem_addr = {req_tag, set, cnt, 2'b00}.
  - On mem_ack=1, write mem_rdata into fill_line word[cnt], then increment cnt. If cnt=WORDS-1, go to DONE.
- DONE:
  - done=1 and busy=1 for exactly one cycle; memory requests are deasserted;
  - next state is IDLE.
- Memory request outputs are registered-state decodes. mem_rden and mem_wen are never both 1.
- mem_ack is ignored in IDLE and DONE.
- req_valid is ignored while busy=1. The controller must re-present a request only after done.
- Counter arithmetic: 3-bit counter with wrap from 7 to 0 on the transition between phases. The offset field of mem_addr is cnt<<2, so addresses are word-aligned.
- Latency with mem_ack tied to 1:
  - fill only: request edge, then 8 FILL cycles, then 1 DONE cycle; done is seen 9 cycles after the capture edge.
  - writeback plus fill: 17 cycles.
- Back-to-back: a new req_valid is accepted in the first IDLE cycle after DONE, so there is 1 idle cycle minimum between operations.
- Bits of fill_line not yet overwritten during FILL keep their previous line's contents. Consumers use fill_line only at done.

Test Plan:
1. Reset, then req_valid=1, req_wb=0, req_tag=24'hABCDE0, req_set=3, mem_ack=1, mem_rdata=0x100+cnt.
   - mem_addr steps 0xABCDE060, 0xABCDE064, … 0xABCDE07C.
   - done pulses once.
   - fill_line word i = 0x100+i.
2. req_wb=1, victim_tag=24'h000123, victim words 0xA0..0xA7, req_tag=24'h000456, set=5.
   - 8 writes to 0x000123A0–0x000123BC with matching wdata.
   - Then 8 reads from 0x000456A0–0x000456BC.
   - done arrives 17 cycles after capture.
3. mem_ack pattern 1,0,0,1 repeating during FILL.
   - Address and rden hold during ack=0.
   - Exactly 8 words are captured in order; no word is skipped or duplicated.
4. Assert req_valid continuously while busy with different tags.
   - Only the first request is serviced.
   - Latched tag and victim data are unchanged despite input toggling.
5. reset_n=0 at word 4 of WB.
   - Next cycle: busy=0, mem_wen=0, fill_line=0, no done.
   - A new fill request afterwards completes normally from cnt=0.
6. Two back-to-back fill requests (second req_valid held high).
   - Second capture occurs in the IDLE cycle after DONE.
   - fill_line holds the first line until the second line's words are written.
